// File: rtl/openhw_ahb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : openhw_ahb_arbiter
//  Purpose  : Two-master AHB-Lite arbiter in front of a single shared bus.
//             An uncontested NONSEQ passes straight through in the same cycle.
//             A master that is not granted, or that requests while the bus is
//             stalled, is captured in a one-entry register and held with
//             HREADYOUT low until its transfer is issued.
//  Ports    : HCLK, reset               clock, synchronous active-high reset
//             M0_* / M1_*               per-master AHB-Lite slave ports
//             HADDR..HWSTRB (out)       shared bus towards the uncore
//             HREADY, HRESP, HRDATA     shared-bus response from the uncore
//             GrantM1                   current address-phase owner (1 = M1)
//  Revision : 1.0  initial release
// ============================================================================

package openhw_ahb_arbiter_pkg;
   typedef struct packed {
      int PA_BITS;
      int AHBW;
      int XLEN;
   } cvw_t;
endpackage

module openhw_ahb_arbiter
   import openhw_ahb_arbiter_pkg::*;
#(
   parameter cvw_t P          = '{PA_BITS: 32, AHBW: 32, XLEN: 32},
   parameter int   ROUNDROBIN = 1
) (
   input  logic                  HCLK,
   input  logic                  reset,
   // master 0
   input  logic [P.PA_BITS-1:0]  M0_HADDR,
   input  logic [1:0]            M0_HTRANS,
   input  logic                  M0_HWRITE,
   input  logic [2:0]            M0_HSIZE,
   input  logic [2:0]            M0_HBURST,
   input  logic [3:0]            M0_HPROT,
   input  logic                  M0_HMASTLOCK,
   input  logic [P.AHBW-1:0]     M0_HWDATA,
   input  logic [P.XLEN/8-1:0]   M0_HWSTRB,
   output logic                  M0_HREADYOUT,
   output logic                  M0_HRESP,
   output logic [P.AHBW-1:0]     M0_HRDATA,
   // master 1
   input  logic [P.PA_BITS-1:0]  M1_HADDR,
   input  logic [1:0]            M1_HTRANS,
   input  logic                  M1_HWRITE,
   input  logic [2:0]            M1_HSIZE,
   input  logic [2:0]            M1_HBURST,
   input  logic [3:0]            M1_HPROT,
   input  logic                  M1_HMASTLOCK,
   input  logic [P.AHBW-1:0]     M1_HWDATA,
   input  logic [P.XLEN/8-1:0]   M1_HWSTRB,
   output logic                  M1_HREADYOUT,
   output logic                  M1_HRESP,
   output logic [P.AHBW-1:0]     M1_HRDATA,
   // shared bus
   output logic [P.PA_BITS-1:0]  HADDR,
   output logic [1:0]            HTRANS,
   output logic                  HWRITE,
   output logic [2:0]            HSIZE,
   output logic [2:0]            HBURST,
   output logic [3:0]            HPROT,
   output logic                  HMASTLOCK,
   output logic [P.AHBW-1:0]     HWDATA,
   output logic [P.XLEN/8-1:0]   HWSTRB,
   input  logic                  HREADY,
   input  logic                  HRESP,
   input  logic [P.AHBW-1:0]     HRDATA,
   output logic                  GrantM1
);

   localparam int         c_pa_w      = P.PA_BITS;
   localparam logic [1:0] c_tr_idle   = 2'b00;
   localparam logic [1:0] c_tr_busy   = 2'b01;
   localparam logic [1:0] c_tr_nonseq = 2'b10;
   localparam logic [1:0] c_tr_seq    = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OWN0 = 2'd1,
      S_OWN1 = 2'd2
   } state_t;

   state_t r_state, w_nxt_state;
   logic   r_grant, w_nxt_grant;   // owner, or parked master when idle
   logic   r_last,  w_nxt_last;    // winner of the most recent tie-break
   logic   r_dvalid;               // a data phase is outstanding
   logic   r_downer;               // master owning that data phase

   logic   w_own;                  // address-phase owner this cycle
   logic   w_active;               // owner's address phase is on the bus

   // live master signals, indexed by master
   logic [c_pa_w-1:0] w_addr  [2];
   logic [1:0]        w_trans [2];
   logic              w_write [2];
   logic [2:0]        w_size  [2];
   logic [2:0]        w_burst [2];
   logic [3:0]        w_prot  [2];
   logic              w_lock  [2];

   // effective signals: capture register while pending, else live
   logic [c_pa_w-1:0] w_eff_addr  [2];
   logic [1:0]        w_eff_trans [2];
   logic              w_eff_write [2];
   logic [2:0]        w_eff_size  [2];
   logic [2:0]        w_eff_burst [2];
   logic [3:0]        w_eff_prot  [2];
   logic              w_eff_lock  [2];

   logic [1:0] w_pend;
   logic [1:0] w_req;
   logic [1:0] w_hold;
   logic [1:0] w_hreadyout;

   assign w_addr[0]  = M0_HADDR;      assign w_addr[1]  = M1_HADDR;
   assign w_trans[0] = M0_HTRANS;     assign w_trans[1] = M1_HTRANS;
   assign w_write[0] = M0_HWRITE;     assign w_write[1] = M1_HWRITE;
   assign w_size[0]  = M0_HSIZE;      assign w_size[1]  = M1_HSIZE;
   assign w_burst[0] = M0_HBURST;     assign w_burst[1] = M1_HBURST;
   assign w_prot[0]  = M0_HPROT;      assign w_prot[1]  = M1_HPROT;
   assign w_lock[0]  = M0_HMASTLOCK;  assign w_lock[1]  = M1_HMASTLOCK;

   for (genvar n = 0; n < 2; n++) begin : g_master
      localparam logic c_id = 1'(n);

      logic              r_pend;
      logic [c_pa_w-1:0] r_cap_addr;
      logic [1:0]        r_cap_trans;
      logic              r_cap_write;
      logic [2:0]        r_cap_size;
      logic [2:0]        r_cap_burst;
      logic [3:0]        r_cap_prot;
      logic              r_cap_lock;
      logic              w_cap;
      logic              w_issued;

      // A new NONSEQ the master believes accepted, but which cannot go out
      // on the shared bus this cycle, is captured.
      assign w_cap = (w_trans[n] == c_tr_nonseq) && w_hreadyout[n] &&
                     (!w_active || (w_own != c_id) || !HREADY);
      assign w_issued = w_active && (w_own == c_id) && HREADY;

      always_ff @(posedge HCLK) begin
         if (reset) begin
            r_pend <= 1'b0;
         end else if (w_cap) begin
            r_pend <= 1'b1;
         end else if (w_issued) begin
            r_pend <= 1'b0;
         end
      end

      always_ff @(posedge HCLK) begin
         if (w_cap) begin
            r_cap_addr  <= w_addr[n];
            r_cap_trans <= w_trans[n];
            r_cap_write <= w_write[n];
            r_cap_size  <= w_size[n];
            r_cap_burst <= w_burst[n];
            r_cap_prot  <= w_prot[n];
            r_cap_lock  <= w_lock[n];
         end
      end

      assign w_pend[n]      = r_pend;
      assign w_eff_addr[n]  = r_pend ? r_cap_addr  : w_addr[n];
      assign w_eff_trans[n] = r_pend ? r_cap_trans : w_trans[n];
      assign w_eff_write[n] = r_pend ? r_cap_write : w_write[n];
      assign w_eff_size[n]  = r_pend ? r_cap_size  : w_size[n];
      assign w_eff_burst[n] = r_pend ? r_cap_burst : w_burst[n];
      assign w_eff_prot[n]  = r_pend ? r_cap_prot  : w_prot[n];
      assign w_eff_lock[n]  = r_pend ? r_cap_lock  : w_lock[n];

      assign w_req[n]  = r_pend || (w_trans[n] == c_tr_nonseq);
      assign w_hold[n] = w_eff_lock[n] || (w_eff_trans[n] == c_tr_seq) ||
                         (w_eff_trans[n] == c_tr_busy);
      assign w_hreadyout[n] = !(r_pend || (r_dvalid && (r_downer == c_id) && !HREADY));
   end

   // Arbitration is resolved combinationally so that an uncontested request
   // reaches the bus in its own cycle; the registered state only records the
   // decision taken at each accepted (HREADY = 1) edge.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_grant = r_grant;
      w_nxt_last  = r_last;
      if (HREADY) begin
         if ((r_state == S_OWN0) && w_hold[0]) begin
            w_nxt_grant = 1'b0;
         end else if ((r_state == S_OWN1) && w_hold[1]) begin
            w_nxt_grant = 1'b1;
         end else if (w_req[0] && w_req[1]) begin
            w_nxt_grant = (ROUNDROBIN != 0) ? ~r_last : 1'b0;
            w_nxt_last  = w_nxt_grant;
            w_nxt_state = w_nxt_grant ? S_OWN1 : S_OWN0;
         end else if (w_req[0]) begin
            w_nxt_grant = 1'b0;
            w_nxt_state = S_OWN0;
         end else if (w_req[1]) begin
            w_nxt_grant = 1'b1;
            w_nxt_state = S_OWN1;
         end else begin
            // nobody asking: park on the previous owner
            w_nxt_state = S_IDLE;
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_grant <= 1'b0;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_nxt_state;
         r_grant <= w_nxt_grant;
         r_last  <= w_nxt_last;
      end
   end

   assign w_own    = w_nxt_grant;
   assign w_active = (w_nxt_state != S_IDLE);
   assign GrantM1  = w_own;

   always_comb begin
      HADDR     = '0;
      HTRANS    = c_tr_idle;
      HWRITE    = 1'b0;
      HSIZE     = '0;
      HBURST    = '0;
      HPROT     = '0;
      HMASTLOCK = 1'b0;
      if (w_active) begin
         HADDR     = w_eff_addr[w_own];
         HTRANS    = w_eff_trans[w_own];
         HWRITE    = w_eff_write[w_own];
         HSIZE     = w_eff_size[w_own];
         HBURST    = w_eff_burst[w_own];
         HPROT     = w_eff_prot[w_own];
         HMASTLOCK = w_eff_lock[w_own];
      end
   end

   always_ff @(posedge HCLK) begin
      if (reset) begin
         r_dvalid <= 1'b0;
         r_downer <= 1'b0;
      end else if (HREADY) begin
         r_dvalid <= HTRANS[1];
         r_downer <= HTRANS[1] ? w_own : 1'b0;
      end
   end

   assign HWDATA = r_downer ? M1_HWDATA : M0_HWDATA;
   assign HWSTRB = r_downer ? M1_HWSTRB : M0_HWSTRB;

   assign M0_HRDATA    = HRDATA;
   assign M1_HRDATA    = HRDATA;
   assign M0_HRESP     = HRESP && r_dvalid && !r_downer;
   assign M1_HRESP     = HRESP && r_dvalid &&  r_downer;
   assign M0_HREADYOUT = w_hreadyout[0];
   assign M1_HREADYOUT = w_hreadyout[1];

endmodule
`default_nettype wire

// File: tb/tb_openhw_ahb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_openhw_ahb_arbiter
//  Purpose  : Self-checking bench for openhw_ahb_arbiter. Expected shared-bus
//             transfers are queued as stimulus is driven and popped when the
//             bus accepts a transfer; other outputs are checked directly.
//  Revision : 1.0  initial release
// ============================================================================
module tb_openhw_ahb_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        r_rst;
   logic [31:0] r_m0_addr,  r_m1_addr;
   logic [1:0]  r_m0_trans, r_m1_trans;
   logic        r_m0_write, r_m1_write;
   logic        r_m0_lock,  r_m1_lock;
   logic [2:0]  r_m0_burst, r_m1_burst;
   logic [31:0] r_m0_wdata, r_m1_wdata;
   logic [3:0]  r_m0_strb,  r_m1_strb;
   logic        r_hready, r_hresp;
   logic [31:0] r_hrdata;

   logic        w_m0_hreadyout, w_m1_hreadyout, w_m0_hresp, w_m1_hresp;
   logic [31:0] w_m0_hrdata, w_m1_hrdata;
   logic [31:0] w_haddr, w_hwdata;
   logic [1:0]  w_htrans;
   logic        w_hwrite, w_hmastlock, w_grant;
   logic [2:0]  w_hsize, w_hburst;
   logic [3:0]  w_hprot, w_hwstrb;

   openhw_ahb_arbiter dut (
      .HCLK(clk), .reset(r_rst),
      .M0_HADDR(r_m0_addr), .M0_HTRANS(r_m0_trans), .M0_HWRITE(r_m0_write),
      .M0_HSIZE(3'b010), .M0_HBURST(r_m0_burst), .M0_HPROT(4'b0011),
      .M0_HMASTLOCK(r_m0_lock), .M0_HWDATA(r_m0_wdata), .M0_HWSTRB(r_m0_strb),
      .M0_HREADYOUT(w_m0_hreadyout), .M0_HRESP(w_m0_hresp), .M0_HRDATA(w_m0_hrdata),
      .M1_HADDR(r_m1_addr), .M1_HTRANS(r_m1_trans), .M1_HWRITE(r_m1_write),
      .M1_HSIZE(3'b010), .M1_HBURST(r_m1_burst), .M1_HPROT(4'b0011),
      .M1_HMASTLOCK(r_m1_lock), .M1_HWDATA(r_m1_wdata), .M1_HWSTRB(r_m1_strb),
      .M1_HREADYOUT(w_m1_hreadyout), .M1_HRESP(w_m1_hresp), .M1_HRDATA(w_m1_hrdata),
      .HADDR(w_haddr), .HTRANS(w_htrans), .HWRITE(w_hwrite), .HSIZE(w_hsize),
      .HBURST(w_hburst), .HPROT(w_hprot), .HMASTLOCK(w_hmastlock),
      .HWDATA(w_hwdata), .HWSTRB(w_hwstrb),
      .HREADY(r_hready), .HRESP(r_hresp), .HRDATA(r_hrdata),
      .GrantM1(w_grant)
   );

   typedef struct packed {
      logic        m;
      logic [31:0] addr;
      logic        wr;
   } xfer_t;

   xfer_t q_exp[$];
   xfer_t r_pop;
   int    n_chk  = 0;
   int    n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic push(input logic m, input logic [31:0] a, input logic w);
      q_exp.push_back('{m: m, addr: a, wr: w});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic idle_all();
      r_m0_trans = 2'b00; r_m1_trans = 2'b00;
      r_m0_lock  = 1'b0;  r_m1_lock  = 1'b0;
      r_m0_write = 1'b0;  r_m1_write = 1'b0;
      r_m0_burst = 3'b000; r_m1_burst = 3'b000;
   endtask

   // bus-side scoreboard: every accepted transfer must match the queue head
   always @(negedge clk) begin
      if (!r_rst && r_hready && w_htrans[1]) begin
         if (q_exp.size() == 0) begin
            chk("bus_unexpected", 64'(q_exp.size()), 64'd1);
         end else begin
            r_pop = q_exp.pop_front();
            chk("bus_xfer", {w_grant, w_haddr, w_hwrite}, {r_pop.m, r_pop.addr, r_pop.wr});
         end
      end
   end

   initial begin
      r_rst = 1'b1;
      idle_all();
      r_m0_addr = '0; r_m1_addr = '0;
      r_m0_wdata = 32'hCAFE0001; r_m1_wdata = 32'hBEEF0002;
      r_m0_strb = 4'hF; r_m1_strb = 4'h3;
      r_hready = 1'b1; r_hresp = 1'b0; r_hrdata = '0;
      repeat (2) tick();

      // ---- reset state ----
      tick(); r_rst = 1'b0; settle();
      chk("rst_htrans", w_htrans, 2'b00);
      chk("rst_haddr", w_haddr, 32'h0);
      chk("rst_lock", w_hmastlock, 1'b0);
      chk("rst_grant", w_grant, 1'b0);
      chk("rst_rdy0", w_m0_hreadyout, 1'b1);
      chk("rst_rdy1", w_m1_hreadyout, 1'b1);
      chk("rst_resp0", w_m0_hresp, 1'b0);
      chk("rst_resp1", w_m1_hresp, 1'b0);

      // ---- solo M0 read, zero added latency ----
      tick(); r_m0_trans = 2'b10; r_m0_addr = 32'h8000_0000; push(1'b0, 32'h8000_0000, 1'b0);
      settle();
      chk("solo_haddr", w_haddr, 32'h8000_0000);
      chk("solo_rdy1", w_m1_hreadyout, 1'b1);
      tick(); idle_all(); r_hrdata = 32'h1234_5678; settle();
      chk("solo_rdata", w_m0_hrdata, 32'h1234_5678);
      chk("solo_rdy0", w_m0_hreadyout, 1'b1);
      chk("solo_rdy1b", w_m1_hreadyout, 1'b1);

      // ---- contention, round robin ----
      tick(); r_m0_trans = 2'b10; r_m0_addr = 32'h100; r_m1_trans = 2'b10; r_m1_addr = 32'h200;
      push(1'b0, 32'h100, 1'b0); push(1'b1, 32'h200, 1'b0); settle();
      chk("rr1_grant", w_grant, 1'b0);
      tick(); idle_all(); settle();
      chk("rr1_rdy1", w_m1_hreadyout, 1'b0);
      chk("rr1_grant2", w_grant, 1'b1);
      tick(); settle();
      chk("rr1_rdy1b", w_m1_hreadyout, 1'b1);
      tick(); r_m0_trans = 2'b10; r_m0_addr = 32'h104; r_m1_trans = 2'b10; r_m1_addr = 32'h204;
      push(1'b1, 32'h204, 1'b0); push(1'b0, 32'h104, 1'b0); settle();
      chk("rr2_grant", w_grant, 1'b1);
      tick(); idle_all(); settle();
      chk("rr2_rdy0", w_m0_hreadyout, 1'b0);
      chk("rr2_grant2", w_grant, 1'b0);
      tick(); settle();

      // ---- locked sequence from M1 ----
      tick(); r_m1_trans = 2'b10; r_m1_lock = 1'b1; r_m1_addr = 32'h300; push(1'b1, 32'h300, 1'b0);
      settle();
      chk("lk_grant1", w_grant, 1'b1);
      tick(); r_m1_addr = 32'h304; r_m0_trans = 2'b10; r_m0_addr = 32'h400;
      push(1'b1, 32'h304, 1'b0); settle();
      chk("lk_grant2", w_grant, 1'b1);
      chk("lk_lock", w_hmastlock, 1'b1);
      tick(); r_m1_addr = 32'h308; r_m0_trans = 2'b00; push(1'b1, 32'h308, 1'b0); settle();
      chk("lk_grant3", w_grant, 1'b1);
      chk("lk_rdy0", w_m0_hreadyout, 1'b0);
      tick(); idle_all(); push(1'b0, 32'h400, 1'b0); settle();
      chk("lk_release", w_grant, 1'b0);
      tick(); settle();

      // ---- M0 write with two wait states, M1 captured meanwhile ----
      tick(); r_m0_trans = 2'b10; r_m0_write = 1'b1; r_m0_addr = 32'h500; push(1'b0, 32'h500, 1'b1);
      settle();
      tick(); idle_all(); r_hready = 1'b0; r_m1_trans = 2'b10; r_m1_addr = 32'h600;
      push(1'b1, 32'h600, 1'b0); settle();
      chk("ws_wdata1", w_hwdata, 32'hCAFE0001);
      chk("ws_strb", w_hwstrb, 4'hF);
      chk("ws_rdy0", w_m0_hreadyout, 1'b0);
      chk("ws_htrans1", w_htrans, 2'b00);
      tick(); r_m1_trans = 2'b00; settle();
      chk("ws_wdata2", w_hwdata, 32'hCAFE0001);
      chk("ws_rdy1", w_m1_hreadyout, 1'b0);
      chk("ws_htrans2", w_htrans, 2'b00);
      tick(); r_hready = 1'b1; settle();
      chk("ws_wdata3", w_hwdata, 32'hCAFE0001);
      chk("ws_grant", w_grant, 1'b1);
      tick(); settle();
      chk("ws_rdy1b", w_m1_hreadyout, 1'b1);

      // ---- two-cycle ERROR to M1, M0 captured and issued afterwards ----
      tick(); r_m1_trans = 2'b10; r_m1_addr = 32'h700; push(1'b1, 32'h700, 1'b0); settle();
      tick(); r_m1_trans = 2'b00; r_hready = 1'b0; r_hresp = 1'b1;
      r_m0_trans = 2'b10; r_m0_addr = 32'h800; push(1'b0, 32'h800, 1'b0); settle();
      chk("err_resp1a", w_m1_hresp, 1'b1);
      chk("err_resp0a", w_m0_hresp, 1'b0);
      chk("err_rdy1", w_m1_hreadyout, 1'b0);
      tick(); r_m0_trans = 2'b00; r_hready = 1'b1; settle();
      chk("err_resp1b", w_m1_hresp, 1'b1);
      chk("err_resp0b", w_m0_hresp, 1'b0);
      chk("err_grant", w_grant, 1'b0);
      chk("err_htrans", w_htrans, 2'b10);
      tick(); r_hresp = 1'b0; settle();
      chk("err_resp0c", w_m0_hresp, 1'b0);
      chk("err_rdy0", w_m0_hreadyout, 1'b1);

      // ---- reset during M0 INCR4 beat 2, with M1 pending ----
      tick(); r_m0_trans = 2'b10; r_m0_burst = 3'b011; r_m0_addr = 32'h900;
      r_m1_trans = 2'b10; r_m1_addr = 32'hA00; push(1'b0, 32'h900, 1'b0); settle();
      chk("rb_grant", w_grant, 1'b0);
      chk("rb_burst", w_hburst, 3'b011);
      tick(); r_m0_trans = 2'b11; r_m0_addr = 32'h904; r_m1_trans = 2'b00; settle();
      chk("rb_rdy1_pend", w_m1_hreadyout, 1'b0);
      r_rst = 1'b1;
      tick(); r_rst = 1'b0; idle_all(); settle();
      chk("rb_htrans", w_htrans, 2'b00);
      chk("rb_rdy0", w_m0_hreadyout, 1'b1);
      chk("rb_rdy1", w_m1_hreadyout, 1'b1);
      chk("rb_grant2", w_grant, 1'b0);
      tick(); settle();
      chk("rb_abandon", w_htrans, 2'b00);

      tick(); settle();
      chk("sb_empty", 64'(q_exp.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/openhw_ahb_arbiter.md
OPENHW_AHB_ARBITER -- requirements
Module: openhw_ahb_arbiter

Interface
REQ-001 Parameter P, cvw_t, none: global configuration; widths use P.PA_BITS, P.AHBW, P.XLEN.
REQ-002 Parameter ROUNDROBIN, 1: 1 = round-robin priority; 0 = fixed priority, M0 highest.
REQ-003 HCLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Mn_HADDR (n=0,1)  input  P.PA_BITS  master n address-phase address.
REQ-006 Mn_HTRANS, Mn_HWRITE, Mn_HSIZE, Mn_HBURST, Mn_HPROT, Mn_HMASTLOCK  input  2,1,3,3,4,1  master n address-phase controls.
REQ-007 Mn_HWDATA, Mn_HWSTRB  input  P.AHBW, P.XLEN/8  master n data-phase write data and strobes.
REQ-008 Mn_HREADYOUT, Mn_HRESP  output  1 each  ready and error response to master n.
REQ-009 Mn_HRDATA  output  P.AHBW  read data to master n.
REQ-010 HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HWSTRB  output  widths as REQ-005..007  shared bus to the uncore.
REQ-011 HREADY, HRESP, HRDATA  input  1,1,P.AHBW  shared-bus response from the uncore.
REQ-012 GrantM1  output  1  current address-phase owner: 0 = M0, 1 = M1.

Function
REQ-013 Each master SHALL have a one-entry capture register (address-phase controls) with a Pending flag.
- Set when the master drives HTRANS NONSEQ while its Mn_HREADYOUT = 1 and the master is not granted, or the bus is not accepting (HREADY = 0).
- Cleared when the captured transfer is issued on the shared bus with HREADY = 1.
REQ-014 Mn_HREADYOUT SHALL be 0 while master n is Pending or owns an outstanding data phase with HREADY = 0; otherwise it SHALL be 1.
REQ-015 The arbiter SHALL be a 3-state machine: IDLE, OWN0, OWN1.
- Transitions occur only on cycles with HREADY = 1.
REQ-016 Hold rules: the owner SHALL keep the grant while its HMASTLOCK = 1, or while it drives HTRANS SEQ or BUSY.
REQ-017 Re-arbitration SHALL occur otherwise.
- Requesters: live NONSEQ or Pending.
- ROUNDROBIN = 1: on simultaneous requests, grant the master not served last.
- ROUNDROBIN = 0: grant M0.
- No requests: go to IDLE with the grant parked on the last owner.
REQ-018 The shared address bus SHALL carry the capture register contents when the owner is Pending, else the owner's live signals.
- Shared HTRANS SHALL be IDLE (00) in state IDLE.
REQ-019 A data-phase owner register SHALL load the address-phase owner when HREADY = 1 and shared HTRANS[1] = 1; it is cleared otherwise when HREADY = 1.
- HWDATA/HWSTRB SHALL be muxed from it.
- HRDATA SHALL go to both masters.
- HRESP SHALL reach only the data-phase owner.
- The non-owner's Mn_HRESP SHALL be 0.
REQ-020 Latency: with no contention, an uncontested NONSEQ SHALL appear on the shared bus in the same cycle (zero added cycles).
- A captured transfer SHALL issue no earlier than the cycle after capture.
REQ-021 Two-cycle ERROR response (HRESP = 1, HREADY = 0 then 1):
- It SHALL be forwarded in both cycles.
- The owner's following SEQ transfer SHALL be dropped if the master drives IDLE.
- Arbitration SHALL proceed normally afterwards.
REQ-022 Simultaneous events:
- Capture and issue of the same master in one cycle SHALL issue the live transfer and leave Pending clear.
- Both masters requesting in the cycle a lock is released SHALL follow REQ-017.

Reset
REQ-023 On reset = 1 at a rising edge, all of the following SHALL hold in the next cycle:
- State = IDLE, GrantM1 = 0, last-served = M1 (M0 wins first tie).
- Pending flags and data-phase owner cleared.
- Shared HTRANS = 00, HADDR = 0, HMASTLOCK = 0.
- M0_HREADYOUT = M1_HREADYOUT = 1, M0_HRESP = M1_HRESP = 0.
REQ-024 Reset asserted mid-transfer SHALL abandon all captured and in-flight transfers without issuing them.

Verification
REQ-025 Solo M0 read: M0 NONSEQ to 0x8000_0000, HREADY = 1 -> shared HADDR = 0x8000_0000 in the same cycle; M0_HRDATA valid next cycle; M1_HREADYOUT stays 1.
REQ-026 Contention, ROUNDROBIN = 1: both masters NONSEQ in the same cycle after reset -> M0 issued first, M1 captured with M1_HREADYOUT = 0, M1 issued next cycle; repeat -> M1 first.
REQ-027 Locked sequence: M1 asserts HMASTLOCK for 3 transfers while M0 requests -> GrantM1 = 1 for all 3; M0 issued the cycle after lock drops.
REQ-028 Wait states: M0 write with 2 cycles of HREADY = 0 -> HWDATA held from M0 for all 3 data cycles; M1 request captured, not issued until HREADY = 1.
REQ-029 Error: slave returns a two-cycle ERROR to M1 -> M1_HRESP = 1 both cycles, M0_HRESP = 0; next pending M0 transfer issues normally.
REQ-030 Reset mid-burst: reset during an M0 INCR4 beat 2 -> next cycle HTRANS = 00, both HREADYOUT = 1, GrantM1 = 0.
